data_memory_responder: RTL and testbench

- Memory-stage responder for the five-stage pipeline. It services load and store requests issued by the memory stage and returns load data toward writeback (the memory-data input of the writeback output multiplexor).
- Models a word-addressed data RAM with configurable access latency.
- Provides a valid/ready request handshake, a one-cycle response pulse, and a stall indication that freezes the pipeline while an access is outstanding.

---
 rtl/data_memory_pkg.sv | 27 ++
 rtl/data_memory_array.sv | 37 +++
 rtl/data_memory_responder.sv | 159 +++++++++++++++
 tb/tb_data_memory_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory responder.
// Address-error rules live here so the top and any future users agree on them.
package data_memory_pkg;

    localparam int unsigned REQ_ADDR_WIDTH   = 32;
    localparam int unsigned WORD_BYTES       = 32 / 8;
    localparam int unsigned BYTE_OFFSET_BITS = 2;
    localparam int unsigned CNT_WIDTH        = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRespond
    } state_e;

    // Error when the byte offset is not the expected lane or any bit above the RAM is set.
    function automatic logic addr_error(input logic [REQ_ADDR_WIDTH-1:0]   addr,
                                        input int unsigned                 addr_width,
                                        input logic [BYTE_OFFSET_BITS-1:0] lane);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[BYTE_OFFSET_BITS-1:0] != lane);
        out_of_range = ((addr >> (addr_width + BYTE_OFFSET_BITS)) != '0);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Single-port word RAM with synchronous read; the read register only updates on re.
// Per-byte write enables exist when DATA_MEMORY_BYTE_ENABLE_EN is defined.
module data_memory_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    input  logic [DATA_WIDTH/8-1:0] be,
`endif
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
`else
            mem[addr] <= wdata;
`endif
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-stage load/store responder: valid/ready request, one-cycle response pulse, stall.
// Optional per-byte store enables via DATA_MEMORY_BYTE_ENABLE_EN.
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_request_valid,
    input  logic                    mem_request_write,
    input  logic [31:0]             mem_request_address,
    input  logic [DATA_WIDTH-1:0]   mem_request_data,
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    input  logic [DATA_WIDTH/8-1:0] mem_request_byte_enable,
`endif
    output logic                    mem_request_ready,
    output logic                    mem_response_valid,
    output logic [DATA_WIDTH-1:0]   mem_response_data,
    output logic                    mem_address_error,
    output logic                    mem_stall
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    zero_q;
    logic                    err_q;

    logic [BYTE_OFFSET_BITS-1:0] lane;
    logic                    req_err;
    logic                    accept;
    logic                    acc_write;
    logic                    acc_err;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_data;
    logic                    enter_respond;
    logic                    ram_we;
    logic                    ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;

`ifdef DATA_MEMORY_BYTE_ENABLE_EN
    logic [NumBytes-1:0]     be_q;
    logic [NumBytes-1:0]     acc_be;

    // Alignment is judged against the lowest enabled lane (lane 0 if none enabled).
    always_comb begin
        lane = '0;
        for (int b = NumBytes - 1; b >= 0; b--) begin
            if (mem_request_byte_enable[b]) begin
                lane = b[BYTE_OFFSET_BITS-1:0];
            end
        end
    end
    assign acc_be = (state_q == StIdle) ? mem_request_byte_enable : be_q;
`else
    assign lane = '0;
`endif

    assign req_err = addr_error(mem_request_address, ADDR_WIDTH, lane);
    assign accept  = (state_q == StIdle) && mem_request_valid;

    // In IDLE the access uses the live request so LATENCY == 1 needs no extra cycle.
    assign acc_write = (state_q == StIdle) ? mem_request_write : write_q;
    assign acc_err   = (state_q == StIdle) ? req_err : 1'b0;
    assign acc_addr  = (state_q == StIdle) ?
                       mem_request_address[ADDR_WIDTH+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS] : addr_q;
    assign acc_data  = (state_q == StIdle) ? mem_request_data : data_q;

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        mem_request_ready  = 1'b0;
        mem_response_valid = 1'b0;
        mem_stall          = 1'b0;
        unique case (state_q)
            StIdle: begin
                mem_request_ready = 1'b1;
                mem_stall         = mem_request_valid;
                if (mem_request_valid) begin
                    cnt_d   = CNT_WIDTH'(LATENCY - 1);
                    state_d = (LATENCY == 1 || req_err) ? StRespond : StWait;
                end
            end
            StWait: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                mem_response_valid = 1'b1;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_respond = (state_d == StRespond) && (state_q != StRespond);
    assign ram_we        = enter_respond && acc_write && !acc_err;
    assign ram_re        = enter_respond && !acc_write && !acc_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= mem_request_write;
                addr_q  <= acc_addr;
                data_q  <= mem_request_data;
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
                be_q    <= mem_request_byte_enable;
`endif
            end
            // Stores and errored accesses answer with zero; loads expose the RAM read register.
            if (enter_respond) begin
                zero_q <= acc_write | acc_err;
                err_q  <= acc_err;
            end
        end
    end

    assign mem_response_data = zero_q ? '0 : ram_rdata;
    assign mem_address_error = err_q && (state_q == StRespond);

    data_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_addr),
        .wdata (acc_data),
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
        .be    (acc_be),
`endif
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: driver queues expected responses,
// a negedge monitor checks data, error flag and arrival cycle.
module tb_data_memory_responder;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid;
    logic          write;
    logic [31:0]   address;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic          ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          stall;

    exp_t        q[$];
    logic [31:0] cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_memory_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .mem_request_valid       (valid),
        .mem_request_write       (write),
        .mem_request_address     (address),
        .mem_request_data        (wdata),
`ifdef DATA_MEMORY_BYTE_ENABLE_EN
        .mem_request_byte_enable (be),
`endif
        .mem_request_ready       (ready),
        .mem_response_valid      (rsp_valid),
        .mem_response_data       (rsp_data),
        .mem_address_error       (rsp_err),
        .mem_stall               (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be_in, input logic [31:0] exp_d, input logic exp_e);
        int unsigned lat;
        lat = exp_e ? 1 : LAT;
        @(negedge clock);
        valid   = 1'b1;
        write   = w;
        address = addr;
        wdata   = data;
        be      = be_in;
        #1;
        check("ready_idle", {31'd0, ready}, 32'd1);
        check("stall_request", {31'd0, stall}, 32'd1);
        q.push_back('{exp_d, exp_e, cyc + lat});
        @(posedge clock);
        #1;
        valid   = 1'b0;
        write   = ~w;
        address = 32'hFFFF_FFFF;
        wdata   = ~data;
        for (int k = 1; k <= int'(lat); k++) begin
            @(negedge clock);
            check("ready_busy", {31'd0, ready}, 32'd0);
            check("stall_busy", {31'd0, stall}, (k < int'(lat)) ? 32'd1 : 32'd0);
            check("rsp_valid_timing", {31'd0, rsp_valid}, (k == int'(lat)) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        check("ready_after", {31'd0, ready}, 32'd1);
        check("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        write   = 1'b0;
        address = '0;
        wdata   = '0;
        be      = 4'hF;
        @(negedge clock);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Store/load round trips, including the last in-range word.
        issue(1'b1, 32'h40,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 32'h40,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 32'h08,  32'h12345678, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 32'h08,  32'h0,        4'hF, 32'h12345678, 1'b0);
        issue(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 32'hFFC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 32'h40,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);

        // Misaligned and out-of-range: one-cycle error response, RAM untouched.
        issue(1'b0, 32'h41,   32'h0,        4'hF, 32'h0, 1'b1);
        issue(1'b1, 32'h41,   32'h01010101, 4'hF, 32'h0, 1'b1);
        issue(1'b0, 32'h40,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 32'h1000, 32'h0,        4'hF, 32'h0, 1'b1);
        issue(1'b1, 32'h1000, 32'h02020202, 4'hF, 32'h0, 1'b1);
        issue(1'b0, 32'h0,    32'h0,        4'hF, 32'h0, 1'b0);

        // Reset during an outstanding store: dropped, no response.
        issue(1'b1, 32'h20, 32'h55555555, 4'hF, 32'h0, 1'b0);
        @(negedge clock);
        valid   = 1'b1;
        write   = 1'b1;
        address = 32'h20;
        wdata   = 32'hAAAAAAAA;
        @(posedge clock);
        #1;
        valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_ready", {31'd0, ready}, 32'd1);
        check("midreset_stall", {31'd0, stall}, 32'd0);
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("post_reset_quiet", {31'd0, rsp_valid}, 32'd0);
        end
        issue(1'b0, 32'h20, 32'h0, 4'hF, 32'h55555555, 1'b0);

`ifdef DATA_MEMORY_BYTE_ENABLE_EN
        issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF,    32'h0, 1'b0);
        issue(1'b1, 32'h30, 32'h00000000, 4'b0011, 32'h0, 1'b0);
        issue(1'b0, 32'h30, 32'h0,        4'hF,    32'hFFFF0000, 1'b0);
`endif

        repeat (3) @(negedge clock);
        check("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
